// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory interface controller: access sizes, FSM states
// and the default bus-timeout length used when DLX_MEM_TIMEOUT_EN is defined.
package dlx_mem_pkg;

    localparam logic [1:0] MEMOP_BYTE = 2'b00;
    localparam logic [1:0] MEMOP_HALF = 2'b01;
    localparam logic [1:0] MEMOP_WORD = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } mem_state_e;

    // MEMOP 2'b11 is an alias of word, so bit 1 alone identifies word accesses.
    function automatic logic is_word_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/dlx_mem_lane.sv
// Combinational lane logic for big-endian byte/half/word accesses: alignment check,
// byte enables, write-data replication and load extraction with sign/zero extension.
module dlx_mem_lane
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  mem_op_i,
    input  logic        mem_signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        aligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[31:24];
        case (addr_lo_i)
            2'b00:   byte_sel = rdata_i[31:24];
            2'b01:   byte_sel = rdata_i[23:16];
            2'b10:   byte_sel = rdata_i[15:8];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        aligned_o = 1'b1;
        be_o      = 4'b1111;
        wdata_o   = wdata_i;
        rdata_o   = rdata_i;
        if (is_word_op(mem_op_i)) begin
            aligned_o = (addr_lo_i == 2'b00);
        end else begin
            case (mem_op_i)
                MEMOP_BYTE: begin
                    be_o    = 4'b1000 >> addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                    rdata_o = {{24{mem_signed_i & byte_sel[7]}}, byte_sel};
                end
                default: begin
                    aligned_o = ~addr_lo_i[0];
                    be_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                    wdata_o   = {2{wdata_i[15:0]}};
                    rdata_o   = {{16{mem_signed_i & half_sel[15]}}, half_sel};
                end
            endcase
        end
    end

endmodule

// File: rtl/dlx_mem_ctrl.sv
// DLX memory controller: turns MemRead/MemWrite levels into one req/ack transaction.
// Optional bus timeout is compiled in with the DLX_MEM_TIMEOUT_EN macro.
module dlx_mem_ctrl
    import dlx_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_op_i,
    input  logic        mem_signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_wait_o,
    output logic [31:0] rdata_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic [29:0] mem_addr_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("dlx_mem_ctrl: TIMEOUT must be in 1..65535");
    end

    mem_state_e  state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        align_err_q;
    logic [1:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic        signed_q;

    logic        req_any;
    logic        is_idle;
    logic        tmo_hit;
    logic [1:0]  lane_op;
    logic [1:0]  lane_addr_lo;
    logic        lane_signed;
    logic        aligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;

    assign req_any = mem_read_i | mem_write_i;
    assign is_idle = (state_q == ST_IDLE);

    // Live request fields drive the lanes in IDLE; afterwards the latched copies do,
    // so load formatting uses the size/offset of the transaction actually in flight.
    assign lane_op      = is_idle ? mem_op_i     : op_q;
    assign lane_addr_lo = is_idle ? addr_i[1:0]  : addr_lo_q;
    assign lane_signed  = is_idle ? mem_signed_i : signed_q;

    dlx_mem_lane u_lane (
        .mem_op_i     (lane_op),
        .mem_signed_i (lane_signed),
        .addr_lo_i    (lane_addr_lo),
        .wdata_i      (wdata_i),
        .rdata_i      (mem_rdata_i),
        .aligned_o    (aligned_d),
        .be_o         (be_d),
        .wdata_o      (wdata_d),
        .rdata_o      (rdata_d)
    );

`ifdef DLX_MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        bus_err_q;

    assign tmo_hit = ((tmo_cnt_q + 16'd1) == 16'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= (state_q == ST_REQ) && !mem_ack_i && tmo_hit;
            if (state_q != ST_REQ) begin
                tmo_cnt_q <= '0;
            end else if (!mem_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign tmo_hit   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            align_err_q <= 1'b0;
            op_q        <= MEMOP_BYTE;
            addr_lo_q   <= '0;
            signed_q    <= 1'b0;
        end else begin
            align_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        if (aligned_d) begin
                            state_q     <= ST_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ~mem_read_i;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= addr_i[31:2];
                            mem_wdata_q <= wdata_d;
                            op_q        <= mem_op_i;
                            addr_lo_q   <= addr_i[1:0];
                            signed_q    <= mem_signed_i;
                        end else begin
                            state_q     <= ST_ERR;
                            align_err_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack arriving in the timeout cycle still completes normally.
                    if (mem_ack_i) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= ST_ERR;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_wait_o  = rst_ni & ((is_idle & req_any) | (state_q == ST_REQ));
    assign rdata_o     = rdata_q;
    assign align_err_o = align_err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// Self-checking bench for dlx_mem_ctrl: directed vector table, multi-cycle corner
// sequences and randomized transactions against a behavioural model.
module tb_dlx_mem_ctrl;
    import dlx_mem_pkg::*;

`ifdef DLX_MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_signed = 1'b0;
    logic [1:0]  mem_op = 2'b00;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_wait, align_err, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;

    dlx_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_op_i(mem_op),
        .mem_signed_i(mem_signed), .addr_i(addr), .wdata_i(wdata),
        .mem_wait_o(mem_wait), .rdata_o(rdata), .align_err_o(align_err), .bus_err_o(bus_err),
        .mem_addr_o(mem_addr), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_rdata = '0;

    // Observations of one transaction
    int          r_waits, r_reqc, r_ap, r_bp;
    logic        r_done, r_we;
    logic [3:0]  r_be;
    logic [29:0] r_maddr;
    logic [31:0] r_wdata, r_rdata;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a, wd, rdw;
        int          dly, waits, reqc;
        logic [3:0]  be;
        logic        we;
        logic [29:0] maddr;
        logic [31:0] mwdata, exp_rdata;
        logic        align;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge with the controller idle.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] op, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                           input int dly);
        r_waits = 0; r_reqc = 0; r_ap = 0; r_bp = 0; r_done = 1'b0;
        r_we = 1'b0; r_be = '0; r_maddr = '0; r_wdata = '0; r_rdata = '0;
        mem_read = rd; mem_write = wr; mem_op = op; mem_signed = sgn;
        addr = a; wdata = wd; mem_rdata = rdw; mem_ack = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (mem_wait) r_waits++;
            if (align_err) r_ap++;
            if (bus_err) r_bp++;
            if (mem_req) begin
                r_reqc++;
                r_be = mem_be; r_we = mem_we; r_maddr = mem_addr; r_wdata = mem_wdata;
                mem_ack = (r_reqc > dly);
            end else begin
                mem_ack = 1'b0;
            end
            if (n > 0 && !mem_wait) begin
                r_done = 1'b1;
                r_rdata = rdata;
                break;
            end
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input int waits, input int reqc, input logic [3:0] be,
                             input logic we, input logic [29:0] maddr, input logic [31:0] mwdata,
                             input logic [31:0] exp_rd, input int ap, input int bp);
        chk({tag, "_done"}, 32'(r_done), 32'd1);
        chk({tag, "_waits"}, r_waits, waits);
        chk({tag, "_reqc"}, r_reqc, reqc);
        chk({tag, "_align"}, r_ap, ap);
        chk({tag, "_bus"}, r_bp, bp);
        chk({tag, "_rdata"}, r_rdata, exp_rd);
        if (reqc > 0) begin
            chk({tag, "_be"}, 32'(r_be), 32'(be));
            chk({tag, "_we"}, 32'(r_we), 32'(we));
            chk({tag, "_maddr"}, 32'(r_maddr), 32'(maddr));
            if (we) chk({tag, "_wdata"}, r_wdata, mwdata);
        end
    endtask

    // Behavioural reference: sizes and lane offsets as plain arithmetic.
    function automatic int op_size(input logic [1:0] op);
        return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_aligned(input logic [1:0] op, input logic [31:0] a);
        return (a % op_size(op)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] op, input logic [31:0] a);
        logic [3:0] be = '0;
        int o = int'(a % 4);
        for (int k = o; k < o + op_size(op); k++) be[3 - k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] op, input logic [31:0] w);
        int sz = op_size(op);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] op, input logic sgn,
                                               input logic [31:0] a, input logic [31:0] rw);
        int sz = op_size(op);
        int o = int'(a % 4);
        logic [31:0] mask, v;
        if (sz == 4) return rw;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (rw >> (8 * (4 - o - sz))) & mask;
        if (sgn && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    initial begin
        tbl[0]  = '{1,0,2'd2,0,32'h100,32'h0,32'hDEADBEEF,0, 2,1,4'b1111,0,30'h40,32'h0,32'hDEADBEEF,0};
        tbl[1]  = '{1,0,2'd0,1,32'h103,32'h0,32'h123456F0,0, 2,1,4'b0001,0,30'h40,32'h0,32'hFFFFFFF0,0};
        tbl[2]  = '{1,0,2'd0,0,32'h103,32'h0,32'h123456F0,0, 2,1,4'b0001,0,30'h40,32'h0,32'h000000F0,0};
        tbl[3]  = '{0,1,2'd1,0,32'h202,32'h0000ABCD,32'h0,3, 5,4,4'b0011,1,30'h80,32'hABCDABCD,32'h000000F0,0};
        tbl[4]  = '{1,0,2'd2,0,32'h101,32'h0,32'h0,0, 1,0,4'b0000,0,30'h0,32'h0,32'h000000F0,1};
        tbl[5]  = '{1,0,2'd1,1,32'h002,32'h0,32'h12348765,1, 3,2,4'b0011,0,30'h0,32'h0,32'hFFFF8765,0};
        tbl[6]  = '{0,1,2'd0,0,32'h301,32'h0000005A,32'h0,0, 2,1,4'b0100,1,30'hC0,32'h5A5A5A5A,32'hFFFF8765,0};
        tbl[7]  = '{1,0,2'd1,0,32'h003,32'h0,32'h0,0, 1,0,4'b0000,0,30'h0,32'h0,32'hFFFF8765,1};
        tbl[8]  = '{0,1,2'd3,0,32'h3FC,32'h01234567,32'h0,0, 2,1,4'b1111,1,30'hFF,32'h01234567,32'hFFFF8765,0};
        tbl[9]  = '{1,1,2'd0,0,32'h000,32'h0,32'hA1B2C3D4,0, 2,1,4'b1000,0,30'h0,32'h0,32'h000000A1,0};
        tbl[10] = '{1,0,2'd0,1,32'h001,32'h0,32'h00800000,0, 2,1,4'b0100,0,30'h0,32'h0,32'hFFFFFF80,0};

        // Reset state, with a request already asserted
        mem_read = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wait", 32'(mem_wait), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misc", {mem_we, mem_be, align_err, bus_err}, 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].wd, tbl[i].rdw, tbl[i].dly);
            check_txn($sformatf("t%0d", i), tbl[i].waits, tbl[i].reqc, tbl[i].be, tbl[i].we,
                      tbl[i].maddr, tbl[i].mwdata, tbl[i].exp_rdata, int'(tbl[i].align), 0);
            $display("vec %0d: addr=%h op=%0d rd=%0d wr=%0d rdata=%h waits=%0d", i, tbl[i].a,
                     tbl[i].op, tbl[i].rd, tbl[i].wr, r_rdata, r_waits);
        end
        model_rdata = 32'hFFFFFF80;

        // Ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        repeat (2) @(negedge clk);
        chk("idle_ack_req", 32'(mem_req), 32'd0);
        chk("idle_ack_rdata", rdata, model_rdata);
        mem_ack = 1'b0;
        $display("seq idle_ack: rdata=%h", rdata);

        // Request inputs change during REQ; latched fields must hold
        mem_read = 1'b1; mem_op = MEMOP_WORD; mem_signed = 1'b0; addr = 32'h104;
        @(negedge clk);
        addr = 32'h999; mem_op = MEMOP_BYTE; mem_read = 1'b0; mem_write = 1'b1;
        #1;
        chk("hold_maddr", 32'(mem_addr), 32'h41);
        chk("hold_we", 32'(mem_we), 32'd0);
        chk("hold_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("hold_rdata", rdata, 32'hCAFEF00D);
        chk("hold_done_wait", 32'(mem_wait), 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        model_rdata = 32'hCAFEF00D;
        $display("seq hold: rdata=%h", rdata);

`ifdef DLX_MEM_TIMEOUT_EN
        run_txn(1'b1, 1'b0, MEMOP_WORD, 1'b0, 32'h20, 32'h0, 32'h55, 1000);
        check_txn("tmo", 5, 4, 4'b1111, 1'b0, 30'h8, 32'h0, model_rdata, 0, 1);
        $display("seq timeout: req_cycles=%0d bus_err=%0d", r_reqc, r_bp);
`endif

        for (int i = 0; i < 150; i++) begin
            logic        rd, wr, sgn, al;
            logic [1:0]  op;
            logic [31:0] a, wd, rw, exp_rd;
            int          dly;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            op = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % op_size(op));
            wd = $urandom; rw = $urandom;
            dly = $urandom_range(0, 3);
            al = model_aligned(op, a);
            exp_rd = (al && rd) ? model_load(op, sgn, a, rw) : model_rdata;
            run_txn(rd, wr, op, sgn, a, wd, rw, dly);
            check_txn($sformatf("r%0d", i), al ? dly + 2 : 1, al ? dly + 1 : 0,
                      model_be(op, a), ~rd, a / 4, model_wdata(op, wd), exp_rd, al ? 0 : 1, 0);
            model_rdata = exp_rd;
            $display("rnd %0d: addr=%h op=%0d rd=%0d rdata=%h", i, a, op, rd, r_rdata);
        end

        // Reset asserted mid-REQ, late ack ignored
        mem_read = 1'b1; mem_op = MEMOP_WORD; addr = 32'h10; mem_rdata = 32'h11111111;
        @(negedge clk);
        chk("mid_rst_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_drop", 32'(mem_req), 32'd0);
        chk("mid_rst_wait", 32'(mem_wait), 32'd0);
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_misc", {mem_req, mem_we, mem_be, align_err, bus_err}, 32'd0);
        chk("mid_rst_maddr", 32'(mem_addr), 32'd0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_req", 32'(mem_req), 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        $display("seq mid_reset: rdata=%h", rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
